// File: rtl/global_types.sv
// Shared types for the data-memory arbiter: owner encoding and bus word widths.
package global_types;

    typedef logic [8:0]  logic9;
    typedef logic [31:0] logic32;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DBG,
        OWN_DBG_LOCKED
    } owner_t;

    localparam logic [15:0] CONFLICT_MAX = 16'hFFFF;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Counts consecutive denied debug-request cycles; expired forces the next debug grant.
module dmem_arb_starve_ctr #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic req,
    input  logic gnt,
    output logic expired
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (!req || gnt) begin
            cnt_q <= '0;
        end else if (cnt_q != LIMIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired = (cnt_q == LIMIT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter (MIPS core vs debug/loader) in front of a single-port
// synchronous-read data memory, with debug lock and starvation relief.
//
// state          | meaning
// OWN_NONE       | no port granted last cycle
// OWN_CPU        | cpu granted last cycle
// OWN_DBG        | dbg granted last cycle, unlocked
// OWN_DBG_LOCKED | dbg granted last cycle with dbg_lock; holds the port
module dmem_arbiter
    import global_types::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic9       cpu_addr,
    input  logic32      cpu_wd,
    output logic        cpu_gnt,
    output logic        cpu_stall,
    output logic        cpu_rvalid,
    output logic32      cpu_rd,
    input  logic        dbg_req,
    input  logic        dbg_we,
    input  logic        dbg_lock,
    input  logic9       dbg_addr,
    input  logic32      dbg_wd,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic32      dbg_rd,
    output logic        mem_we,
    output logic9       mem_addr,
    output logic32      mem_wd,
    input  logic32      mem_rd,
    output logic [15:0] conflict_cnt
);

    owner_t state_q, state_d;
    logic   lock_q;
    logic   starve_expired;

    dmem_arb_starve_ctr #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_starve (
        .clock   (clock),
        .reset   (reset),
        .req     (dbg_req),
        .gnt     (dbg_gnt),
        .expired (starve_expired)
    );

    // A held lock is dropped in the same cycle dbg_lock falls, so the
    // grant below is already re-arbitrated without it.
    assign lock_q = (state_q == OWN_DBG_LOCKED);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= OWN_NONE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        cpu_gnt  = 1'b0;
        dbg_gnt  = 1'b0;
        state_d  = OWN_NONE;
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_wd   = '0;
        if (!reset) begin
            if (dbg_req && ((lock_q && dbg_lock) || starve_expired || !cpu_req)) begin
                dbg_gnt = 1'b1;
            end else if (cpu_req) begin
                cpu_gnt = 1'b1;
            end
        end
        if (dbg_gnt) begin
            state_d  = dbg_lock ? OWN_DBG_LOCKED : OWN_DBG;
            mem_we   = dbg_we;
            mem_addr = dbg_addr;
            mem_wd   = dbg_wd;
        end else if (cpu_gnt) begin
            state_d  = OWN_CPU;
            mem_we   = cpu_we;
            mem_addr = cpu_addr;
            mem_wd   = cpu_wd;
        end
    end

    assign cpu_stall = cpu_req && !cpu_gnt && !reset;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            dbg_rvalid <= dbg_gnt && !dbg_we;
        end
    end

    assign cpu_rd = cpu_rvalid ? mem_rd : '0;
    assign dbg_rd = dbg_rvalid ? mem_rd : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            conflict_cnt <= '0;
        end else if (cpu_req && dbg_req && (conflict_cnt != CONFLICT_MAX)) begin
            conflict_cnt <= conflict_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural arbitration/memory model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_dmem_arbiter;

    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [8:0]  cpu_addr = '0;
    logic [31:0] cpu_wd = '0;
    logic        cpu_gnt, cpu_stall, cpu_rvalid;
    logic [31:0] cpu_rd;
    logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
    logic [8:0]  dbg_addr = '0;
    logic [31:0] dbg_wd = '0;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rd;
    logic        mem_we;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd = '0;
    logic [15:0] conflict_cnt;

    int errors = 0;
    int checks = 0;

    dmem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
        .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rd(cpu_rd),
        .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr),
        .dbg_wd(dbg_wd), .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rd(dbg_rd),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd),
        .conflict_cnt(conflict_cnt)
    );

    always #5 clock = ~clock;

    // External single-port memory, 1-cycle synchronous read
    logic [31:0] mem_arr [512];
    always @(posedge clock) begin
        if (mem_we) mem_arr[mem_addr] <= mem_wd;
        mem_rd <= mem_arr[mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    int          m_starve = 0;
    int          m_conf = 0;
    bit          m_lock = 0;
    bit          m_cpu_rv = 0, m_dbg_rv = 0;
    logic [31:0] m_cpu_rd = '0, m_dbg_rd = '0;
    logic [31:0] shadow [512];
    bit          e_cgnt, e_dgnt, e_we;
    logic [8:0]  e_addr;
    logic [31:0] e_wd;

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_arr[i] = '0;
            shadow[i]  = '0;
        end
    end

    always @(negedge clock) begin
        e_dgnt = !reset && dbg_req && ((m_lock && dbg_lock) || (m_starve >= LIMIT) || !cpu_req);
        e_cgnt = !reset && cpu_req && !e_dgnt;
        e_we   = e_dgnt ? dbg_we : (e_cgnt ? cpu_we : 1'b0);
        e_addr = e_dgnt ? dbg_addr : (e_cgnt ? cpu_addr : 9'd0);
        e_wd   = e_dgnt ? dbg_wd : (e_cgnt ? cpu_wd : 32'd0);
        chk("cpu_gnt", cpu_gnt, e_cgnt);
        chk("dbg_gnt", dbg_gnt, e_dgnt);
        chk("cpu_stall", cpu_stall, !reset && cpu_req && !e_cgnt);
        chk("mem_we", mem_we, e_we);
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wd", mem_wd, e_wd);
        chk("cpu_rvalid", cpu_rvalid, m_cpu_rv);
        chk("dbg_rvalid", dbg_rvalid, m_dbg_rv);
        chk("cpu_rd", cpu_rd, m_cpu_rv ? m_cpu_rd : 32'd0);
        chk("dbg_rd", dbg_rd, m_dbg_rv ? m_dbg_rd : 32'd0);
        chk("conflict_cnt", conflict_cnt, m_conf);
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_starve = 0;
            m_conf   = 0;
            m_lock   = 0;
            m_cpu_rv = 0;
            m_dbg_rv = 0;
        end else begin
            if (cpu_req && dbg_req && m_conf < 65535) m_conf = m_conf + 1;
            m_starve = (dbg_req && !e_dgnt) ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
            m_lock   = e_dgnt && dbg_lock;
            m_cpu_rv = e_cgnt && !cpu_we;
            m_dbg_rv = e_dgnt && !dbg_we;
            m_cpu_rd = shadow[cpu_addr];
            m_dbg_rd = shadow[dbg_addr];
            if (e_we) shadow[e_addr] = e_wd;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [8:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic dl, input logic [8:0] da,
                         input logic [31:0] dd);
        cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wd = cd;
        dbg_req = dr; dbg_we = dw; dbg_lock = dl; dbg_addr = da; dbg_wd = dd;
    endtask

    task automatic reset_pulse();
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Requests held during reset must still see no grants
        drive(1, 1, 9'h10, 32'h55, 1, 1, 0, 9'h11, 32'h66);
        repeat (2) @(negedge clock);
        chk("rst_cpu_gnt", cpu_gnt, 0);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_stall", cpu_stall, 0);
        chk("rst_mem_we", mem_we, 0);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Idle
        @(negedge clock);
        chk("idle_mem_we", mem_we, 0);
        chk("idle_mem_addr", mem_addr, 0);
        chk("idle_gnts", {cpu_gnt, dbg_gnt}, 0);
        chk("idle_rvalids", {cpu_rvalid, dbg_rvalid}, 0);
        chk("idle_conflict", conflict_cnt, 0);

        // Solo CPU write then read of 0x1FC
        tick();
        drive(1, 1, 9'h1FC, 32'h4, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("solo_wr_gnt", cpu_gnt, 1);
        chk("solo_wr_we", mem_we, 1);
        chk("solo_wr_addr", mem_addr, 9'h1FC);
        chk("solo_wr_wd", mem_wd, 32'h4);
        tick();
        drive(1, 0, 9'h1FC, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("solo_rd_gnt", cpu_gnt, 1);
        chk("solo_rd_rvalid_early", cpu_rvalid, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("solo_rvalid", cpu_rvalid, 1);
        chk("solo_rd", cpu_rd, 32'h4);
        chk("solo_dbg_out", {dbg_gnt, dbg_rvalid, dbg_rd}, 0);

        // Contention: both read for 10 cycles -> C,C,C,C,D repeating
        reset_pulse();
        drive(1, 0, 9'h1FC, 0, 1, 0, 0, 9'h1FC, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            chk("cont_dbg_gnt", dbg_gnt, (i % 5) == 4);
            chk("cont_cpu_gnt", cpu_gnt, (i % 5) != 4);
            chk("cont_stall", cpu_stall, (i % 5) == 4);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("cont_conflict", conflict_cnt, 10);

        // Locked 3-beat debug write against a continuously requesting cpu
        reset_pulse();
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 9'h020, 0, i < 7, 1, 1, 9'h1E0 + 9'(4 * ((i < 4) ? 0 : i - 4)), 32'hA0 + 32'(i));
            @(negedge clock);
            chk("lock_dbg_gnt", dbg_gnt, (i >= 4) && (i < 7));
            chk("lock_cpu_gnt", cpu_gnt, (i < 4) || (i == 7));
            chk("lock_stall", cpu_stall, (i >= 4) && (i < 7));
            if (i >= 4 && i < 7) chk("lock_addr", mem_addr, 9'h1E0 + 9'(4 * (i - 4)));
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        tick();

        // Reset arriving while a cpu read is in flight
        drive(1, 0, 9'h1FC, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("rmr_gnt", cpu_gnt, 1);
        #2;
        reset = 1'b1;
        dbg_req = 1'b1;
        @(negedge clock);
        chk("rmr_rvalid", cpu_rvalid, 0);
        chk("rmr_conflict", conflict_cnt, 0);
        chk("rmr_gnts", {cpu_gnt, dbg_gnt}, 0);
        tick();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clock);
        chk("rmr_rvalid_after", cpu_rvalid, 0);

        // Randomised traffic with occasional reset pulses
        for (int i = 0; i < 3000; i++) begin
            tick();
            reset = ($urandom_range(0, 149) == 0);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 9'($urandom_range(0, 15)), $urandom,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                  9'($urandom_range(0, 15)), $urandom);
        end
        tick();
        reset = 1'b0;

        // Saturation of conflict_cnt
        reset_pulse();
        drive(1, 0, 9'h001, 0, 1, 0, 0, 9'h002, 0);
        repeat (70000) tick();
        @(negedge clock);
        chk("sat_conflict", conflict_cnt, 16'hFFFF);

        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
